otter_mmio_hub: RTL
===================

Name: otter_mmio_hub

Overview:
- Parametrised memory-mapped I/O hub between the OTTER IOBUS and the board peripherals.
- Replaces the fixed switch/LED/7-seg decode with a configurable address map:
  - readable output registers;
  - per-button debouncing;
  - a maskable, write-1-to-clear interrupt controller that drives the CPU INTR input.
- Sits in the wrapper in the CPU clock domain; SevSegDisp consumes its SSEG output.

Parameters:
- BASE_AD, 32'h11000000, base address of the register map; register stride is 0x20.
- SW_W, 16, switch input width (1..32).
- LED_W, 16, LED register width (1..32).
- NUM_BTN, 4, number of debounced buttons/interrupt sources (1..16).
- DB_CYCLES, 50000, consecutive stable cycles required to accept a button change (>=2).

Ports:
- CLK  in  1  CPU clock; all state on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- IOBUS_ADDR  in  32  bus address from CPU.
- IOBUS_OUT  in  32  write data from CPU.
- IOBUS_WR  in  1  write strobe, one cycle per store.
- IOBUS_IN  out  32  read data to CPU.
- SWITCHES  in  SW_W  board switches (already static levels; no debounce).
- BTNS  in  NUM_BTN  raw asynchronous buttons, active-high.
- LEDS  out  LED_W  LED register.
- SSEG  out  16  seven-segment data register.
- INTR  out  1  interrupt request to CPU.

Behaviour:
- Register map (offset from BASE_AD):
  - 0x00 SW (R)
  - 0x20 LEDS (R/W)
  - 0x40 SSEG (R/W)
  - 0x60 BTN_LVL (R, debounced levels)
  - 0x80 INT_PEND (R, W1C)
  - 0xA0 INT_MASK (R/W)
- Decode is exact 32-bit address compare.
  - Unmapped or unaligned address: read returns 0; write ignored.
  - Writes to R-only registers are ignored.
- Reads are combinational: IOBUS_IN is valid the same cycle as IOBUS_ADDR.
  - Narrower registers are zero-extended to 32 bits.
- Writes take effect on the CLK edge where IOBUS_WR=1. Only the low bits of IOBUS_OUT are used; upper bits are dropped.
- Reset (RESETN=0, asynchronous): LEDS=0, SSEG=0, INT_MASK=0, INT_PEND=0, INTR=0, all debounced levels=0, debounce counters=0, synchronisers=0.
- Debounce, per button:
  - 2-flop synchroniser, then a counter of width clog2(DB_CYCLES).
  - Counter clears whenever the synced sample equals the debounced level.
  - Counter increments while they differ.
  - On the edge where the counter equals DB_CYCLES-1 and the inputs still differ, the level flips and the counter clears.
  - A change that holds stable propagates to BTN_LVL exactly DB_CYCLES+2 edges after the pin changes.
  - A glitch shorter than DB_CYCLES synced cycles causes no change.
- Interrupt controller:
  - A 0->1 transition of debounced level i sets INT_PEND[i] on the same edge the level flips. Falling transitions do not set pending.
  - Writing INT_PEND with bit i=1 clears pending bit i; bits written 0 are unchanged.
  - Simultaneous set and clear of the same bit in one cycle: set wins, and the bit stays 1.
  - Pending bits latch regardless of the mask; the mask gates only INTR.
  - INTR is registered: INTR <= |(INT_PEND & INT_MASK), so INTR appears one edge after the pending/mask change and drops one edge after the clear.
  - INTR stays high while any enabled pending bit is set (level interrupt).
- Reset asserted mid-debounce or with interrupts pending clears everything immediately. After release, no pending event is generated for buttons that are already held: the level rises through debounce, and that rise sets pending normally.

Test Plan (DB_CYCLES=4, NUM_BTN=4, default BASE_AD):
- Reset, then read 0x11000020, 0x11000040, 0x11000080, 0x110000A0 -> all 0; INTR=0; LEDS=0; SSEG=0.
- Write 0xFFFF_A5C3 to 0x11000020, then read it back -> LEDS=16'hA5C3, read returns 0x0000A5C3. Write to 0x11000024 -> LEDS unchanged. Read of 0x11000000 with SWITCHES=16'h1234 -> 0x00001234 in the same cycle.
- BTNS[1] high for 3 cycles then low -> BTN_LVL stays 0, INT_PEND stays 0. BTNS[1] held high -> BTN_LVL=4'b0010 exactly 6 edges after the pin change, and INT_PEND=4'b0010 on the same edge.
- Starting from INT_PEND=4'b0010 with mask 0 -> INTR stays 0. Write INT_MASK=0x2 -> INTR=1 one edge later. Write 0x2 to INT_PEND -> pending clears and INTR=0 one edge after the clear.
- Write W1C of bit 0 on the same edge that button 0's debounced level rises -> INT_PEND[0]=1 (set wins).
- Hold BTNS=4'b1111 with INT_MASK=0xF, pulse RESETN low mid-debounce -> outputs clear asynchronously. After release, INT_PEND=4'hF 6 edges later, and INTR=1 one edge after that.

Source files
------------

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the OTTER IOBUS: switches, LEDs, seven-segment data,
// debounced buttons and a maskable W1C level interrupt controller.
module otter_mmio_hub #(
    parameter logic [31:0] BASE_AD   = 32'h11000000,
    parameter int          SW_W      = 16,
    parameter int          LED_W     = 16,
    parameter int          NUM_BTN   = 4,
    parameter int          DB_CYCLES = 50000
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        IOBUS_IN,
    input  logic [SW_W-1:0]    SWITCHES,
    input  logic [NUM_BTN-1:0] BTNS,
    output logic [LED_W-1:0]   LEDS,
    output logic [15:0]        SSEG,
    output logic               INTR
);

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    localparam logic [31:0] AD_SW   = BASE_AD + 32'h00;
    localparam logic [31:0] AD_LED  = BASE_AD + 32'h20;
    localparam logic [31:0] AD_SSEG = BASE_AD + 32'h40;
    localparam logic [31:0] AD_BTN  = BASE_AD + 32'h60;
    localparam logic [31:0] AD_PEND = BASE_AD + 32'h80;
    localparam logic [31:0] AD_MASK = BASE_AD + 32'hA0;

    logic [LED_W-1:0]   led_q,  led_d;
    logic [15:0]        sseg_q, sseg_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic               intr_q, intr_d;
    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_rise;

    logic wr_led, wr_sseg, wr_pend, wr_mask;

    assign wr_led  = IOBUS_WR && (IOBUS_ADDR == AD_LED);
    assign wr_sseg = IOBUS_WR && (IOBUS_ADDR == AD_SSEG);
    assign wr_pend = IOBUS_WR && (IOBUS_ADDR == AD_PEND);
    assign wr_mask = IOBUS_WR && (IOBUS_ADDR == AD_MASK);

    // Per-button synchroniser and debounce counter; the level flips only after
    // the synced input has disagreed with it for DB_CYCLES consecutive edges.
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic             s1_q, s2_q;
        logic             lvl_q, lvl_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            lvl_d = lvl_q;
            cnt_d = cnt_q;
            if (s2_q == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                lvl_d = ~lvl_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= BTNS[gi];
                s2_q  <= s1_q;
                lvl_q <= lvl_d;
                cnt_q <= cnt_d;
            end
        end

        assign btn_lvl[gi]  = lvl_q;
        assign btn_rise[gi] = lvl_d & ~lvl_q;
    end

    always_comb begin
        led_d  = wr_led  ? IOBUS_OUT[LED_W-1:0]   : led_q;
        sseg_d = wr_sseg ? IOBUS_OUT[15:0]        : sseg_q;
        mask_d = wr_mask ? IOBUS_OUT[NUM_BTN-1:0] : mask_q;
        // A rising level in the same cycle as its W1C keeps the bit set.
        pend_d = (pend_q & ~(wr_pend ? IOBUS_OUT[NUM_BTN-1:0] : '0)) | btn_rise;
        intr_d = |(pend_q & mask_q);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            led_q  <= '0;
            sseg_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            intr_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            sseg_q <= sseg_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            intr_q <= intr_d;
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        case (IOBUS_ADDR)
            AD_SW:   IOBUS_IN = 32'(SWITCHES);
            AD_LED:  IOBUS_IN = 32'(led_q);
            AD_SSEG: IOBUS_IN = 32'(sseg_q);
            AD_BTN:  IOBUS_IN = 32'(btn_lvl);
            AD_PEND: IOBUS_IN = 32'(pend_q);
            AD_MASK: IOBUS_IN = 32'(mask_q);
            default: IOBUS_IN = '0;
        endcase
    end

    assign LEDS = led_q;
    assign SSEG = sseg_q;
    assign INTR = intr_q;

endmodule
